ram_loader: RTL

- Controller that owns the 16x8 program RAM write port while a program is loaded, and holds the CPU off the RAM during that time.
- Accepts a byte stream over a valid/ready handshake and writes the bytes to consecutive addresses starting at 0.
- Reads the image back and compares an 8-bit additive checksum, then reports done or error.
- Sits between the external program-entry interface and the RAM, alongside the control decoder; cpu_hold gates the CPU clock.

---
 rtl/ram_loader_if.sv | 30 +++
 rtl/ram_loader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ram_loader_if.sv
// ram_loader_if: stream-in and RAM-port bundle for the program loader.
//   in_data/in_valid/in_last  byte stream from program-entry source
//   in_ready                  loader accepts in_data this cycle
//   ram_addr/ram_wdata/ram_we RAM port driven by the loader (registered)
//   ram_rdata                 RAM read data, one cycle after ram_addr
// modport master: the environment side (stream source + RAM storage).
// modport slave : the loader side.
interface ram_loader_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_last;
   logic              in_ready;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;

   modport master (
      output in_data, in_valid, in_last, ram_rdata,
      input  in_ready, ram_addr, ram_wdata, ram_we
   );

   modport slave (
      input  in_data, in_valid, in_last, ram_rdata,
      output in_ready, ram_addr, ram_wdata, ram_we
   );
endinterface

// File: rtl/ram_loader.sv
// ram_loader: owns the program RAM write port while a program is loaded.
// Accepts a byte stream, writes it to consecutive addresses from 0, reads
// the image back, and compares an additive checksum of what was written
// against what was read. cpu_hold keeps the CPU clock gated meanwhile.
// Ports:
//   clk, rst      clock; synchronous active-low reset
//   start         one-cycle load request (honoured in IDLE/DONE/ERR only)
//   abort         cancel anything, back to IDLE (highest priority)
//   bus           ram_loader_if.slave: stream in + RAM port
//   cpu_hold/busy high while loading or verifying
//   done/error    sticky verify result, cleared by start or abort
//   byte_count    bytes written in current/last load (0..2**ADDR_W)
module ram_loader #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   ram_loader_if.slave       bus,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   byte_count
);

   typedef enum logic [2:0] {
      IDLE, ACCEPT, WRITE, VRD, VCHK, DONE, ERR
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
   localparam logic [ADDR_W:0]   CNT_ONE  = 1;

   state_t            state, state_n;
   logic [ADDR_W-1:0] addr_ptr;
   logic [ADDR_W:0]   vcnt;        // VRD cycle index, 0..byte_count
   logic [DATA_W-1:0] wsum, rsum;
   logic              last_flag;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_we;
   logic              in_ready;
   logic              hs;

   assign bus.ram_addr  = ram_addr;
   assign bus.ram_wdata = ram_wdata;
   assign bus.ram_we    = ram_we;
   assign bus.in_ready  = in_ready;

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   // ---------------------------------------------------------------
   // Next state and state-decoded outputs
   // ---------------------------------------------------------------
   always_comb begin
      state_n  = state;
      in_ready = 1'b0;
      hs       = 1'b0;
      busy     = 1'b0;
      unique case (state)
         IDLE, DONE, ERR: begin
            if (start) state_n = ACCEPT;
         end
         ACCEPT: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            if (bus.in_valid) begin
               hs      = 1'b1;
               state_n = WRITE;
            end
         end
         WRITE: begin
            busy    = 1'b1;
            state_n = last_flag ? VRD : ACCEPT;
         end
         VRD: begin
            busy = 1'b1;
            // byte_count issue cycles plus one to capture the last read
            if (vcnt == byte_count) state_n = VCHK;
         end
         VCHK: begin
            busy    = 1'b1;
            state_n = (rsum == wsum) ? DONE : ERR;
         end
         default: state_n = IDLE;
      endcase
      // abort wins over start and over a pending handshake; in_ready
      // drops in the same cycle so the source never sees a false accept
      if (abort) begin
         state_n  = IDLE;
         in_ready = 1'b0;
         hs       = 1'b0;
      end
      cpu_hold = busy;
   end

   // ---------------------------------------------------------------
   // Datapath: address pointer, RAM port, checksums, status
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         addr_ptr   <= '0;
         vcnt       <= '0;
         wsum       <= '0;
         rsum       <= '0;
         last_flag  <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
         ram_we     <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         byte_count <= '0;
      end else if (abort) begin
         // byte_count deliberately kept so the partial load is visible
         ram_we <= 1'b0;
         done   <= 1'b0;
         error  <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  addr_ptr   <= '0;
                  byte_count <= '0;
                  wsum       <= '0;
                  rsum       <= '0;
                  done       <= 1'b0;
                  error      <= 1'b0;
               end
            end
            ACCEPT: begin
               if (hs) begin
                  ram_addr  <= addr_ptr;
                  ram_wdata <= bus.in_data;
                  ram_we    <= 1'b1;
                  wsum      <= wsum + bus.in_data;
                  // a full RAM ends the load even without in_last
                  last_flag <= bus.in_last | (addr_ptr == ADDR_MAX);
               end
            end
            WRITE: begin
               ram_we     <= 1'b0;
               byte_count <= byte_count + CNT_ONE;
               if (last_flag) begin
                  // first readback address must be on the bus in VRD cycle 0
                  addr_ptr <= '0;
                  vcnt     <= '0;
                  ram_addr <= '0;
               end else begin
                  addr_ptr <= addr_ptr + ADDR_ONE;
               end
            end
            VRD: begin
               vcnt <= vcnt + CNT_ONE;
               // rdata now reflects the address issued in the previous cycle
               if (vcnt != '0) rsum <= rsum + bus.ram_rdata;
               if ((vcnt + CNT_ONE) < byte_count) begin
                  ram_addr <= vcnt[ADDR_W-1:0] + ADDR_ONE;
                  addr_ptr <= vcnt[ADDR_W-1:0] + ADDR_ONE;
               end
            end
            VCHK: begin
               if (rsum == wsum) done  <= 1'b1;
               else              error <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
